// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between MEM and data_memory.
// Optional load forwarding from queued stores: define STORE_FWD_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        req_ready,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_read,
    output logic        dm_mem_write,
    output logic [2:0]  dm_size,
    input  logic [31:0] dm_read_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [5:0]    e_addr [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [2:0]    e_size [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic is_load;
    logic is_store;
    logic full;
    logic hit;
    logic load_acc;
    logic load_mem;
    logic store_acc;
    logic push;
    logic drain;

`ifdef STORE_FWD_EN
    logic [31:0] hit_data;
    logic [2:0]  hit_size;
    logic [31:0] fwd_data;
    logic        fwd_sel;

    // Rebuild the word image a queued store leaves in memory, then
    // apply the load's own extension to it.
    function automatic logic [31:0] fwd_value(
        input logic [31:0] d,
        input logic [2:0]  ssize,
        input logic [2:0]  lsize
    );
        logic [31:0] img;
        unique case (ssize)
            3'b001:  img = {24'b0, d[7:0]};
            3'b010:  img = {16'b0, d[15:0]};
            default: img = d;
        endcase
        unique case (lsize)
            3'b001:  fwd_value = {{24{img[7]}}, img[7:0]};
            3'b010:  fwd_value = {{16{img[15]}}, img[15:0]};
            3'b101:  fwd_value = {24'b0, img[7:0]};
            3'b110:  fwd_value = {16'b0, img[15:0]};
            default: fwd_value = img;
        endcase
    endfunction
`endif

    assign is_load  = req_valid & req_read & ~rst;
    assign is_store = req_valid & req_write & ~req_read & ~rst;
    assign full     = (count == CW'(DEPTH));

    // Scan pending entries oldest to youngest; the last match is the youngest.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_FWD_EN
        hit_data = '0;
        hit_size = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count &&
                e_addr[head + PW'(i)] == req_addr[5:0]) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                hit_data = e_data[head + PW'(i)];
                hit_size = e_size[head + PW'(i)];
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign load_acc = is_load;
`else
    assign load_acc = is_load & ~hit;
`endif
    assign load_mem  = is_load & ~hit;
    assign store_acc = is_store & ~full;
    assign push      = store_acc & (req_size inside {3'b001, 3'b010, 3'b011});
    assign drain     = ~load_mem & (count != '0);
    assign req_ready = load_acc | store_acc;
    assign empty     = (count == '0);

    // Memory port: an issued load wins, otherwise the FIFO head drains.
    always_comb begin
        dm_addr       = '0;
        dm_write_data = '0;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_size       = '0;
        if (load_mem) begin
            dm_mem_read = 1'b1;
            dm_addr     = req_addr;
            dm_size     = req_size;
        end else if (drain) begin
            dm_mem_write  = 1'b1;
            dm_addr       = {26'b0, e_addr[head]};
            dm_write_data = e_data[head];
            dm_size       = e_size[head];
        end
    end

    // Entry storage; contents are meaningless outside the count window.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= req_addr[5:0];
            e_data[tail] <= req_wdata;
            e_size[tail] <= req_size;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(drain);
        end
    end

`ifdef STORE_FWD_EN
    // One-cycle load response, with the forwarded word held locally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            fwd_sel    <= 1'b0;
            fwd_data   <= '0;
        end else begin
            resp_valid <= load_acc;
            fwd_sel    <= load_acc & ~load_mem;
            if (load_acc & ~load_mem) begin
                fwd_data <= fwd_value(hit_data, hit_size, req_size);
            end
        end
    end

    assign resp_data = fwd_sel ? fwd_data : dm_read_data;
`else
    // One-cycle load response; data comes straight from memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= load_acc;
        end
    end

    assign resp_data = dm_read_data;
`endif

endmodule
